// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter for 16 requesters sharing one 4-to-16
// decoded resource. It drives the decoder select (gnt_idx), the enable
// (gnt_vld) and the decoded one-hot grant (gnt). All outputs are registered.
// The rotating search starts just after the last granted index. A bounded
// hold time (MAX_HOLD, 0 = unlimited) keeps contended requesters from starving.
// Optional feature macro: RR_ARB_LOCK_EN adds a lock input. While lock is high,
// preemption of the current holder is suppressed.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_vld
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_vld_q, gnt_vld_d;
  logic [15:0] gnt_q, gnt_d;

  logic        lock_i;
  logic [15:0] others;
  logic [4:0]  win_all;
  logic [4:0]  win_oth;
  logic        take_new;
  logic [3:0]  new_idx;

`ifdef RR_ARB_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 1'b0;
`endif

  // Rotating priority search: returns {found, index} of the first set bit of
  // vec, scanning start, start+1, ... with wrap from 15 to 0. The loop scans
  // the largest offset first so the smallest offset wins.
  function automatic logic [4:0] rr_search(input logic [15:0] vec,
                                           input logic [3:0]  start);
    logic [4:0] res;
    logic [3:0] k;
    res = 5'b0;
    for (int i = 15; i >= 0; i--) begin
      k = start + 4'(i);
      if (vec[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  // Requests other than the current holder. These are the candidates when the
  // holder is preempted.
  assign others  = req & ~gnt_q;
  assign win_all = rr_search(req, ptr_q);
  assign win_oth = rr_search(others, ptr_q);

  // Next-state, pointer, hold counter and registered-output computation
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    take_new   = 1'b0;
    new_idx    = win_all[3:0];

    case (state_q)
      IDLE: begin
        if (win_all[4]) take_new = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          // The holder released. Hand off directly, with no idle cycle.
          if (win_all[4]) begin
            take_new = 1'b1;
          end else begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
          end
        end else if (!lock_i && (MAX_HOLD_C != 8'd0) &&
                     (hold_cnt_q >= MAX_HOLD_C) && win_oth[4]) begin
          // The hold budget is spent and someone else is waiting.
          take_new = 1'b1;
          new_idx  = win_oth[3:0];
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase

    if (take_new) begin
      state_d    = GRANT;
      gnt_idx_d  = new_idx;
      gnt_vld_d  = 1'b1;
      ptr_d      = new_idx + 4'd1;
      hold_cnt_d = 8'd1;
    end

    // The decoded grant always tracks the next select and enable.
    gnt_d = gnt_vld_d ? (16'h0001 << gnt_idx_d) : 16'h0000;
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 4'h0;
      hold_cnt_q <= 8'h00;
      gnt_idx_q  <= 4'h0;
      gnt_vld_q  <= 1'b0;
      gnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: self-checking bench for rr_arbiter_16. It runs two
// instances side by side, one with MAX_HOLD=8 and one with MAX_HOLD=0. Both
// are checked against a behavioural arbitration model, plus directed checks.
// Lock tests are included when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        lock;

  logic [15:0] gnt_a, gnt_b;
  logic [3:0]  idx_a, idx_b;
  logic        vld_a, vld_b;

  int checks = 0;
  int errors = 0;

  // Model state, one entry per instance: [0] MAX_HOLD=8, [1] MAX_HOLD=0
  int mh[2] = '{8, 0};
  bit m_vld[2];
  int m_idx[2];
  int m_last[2];
  int m_hold[2];

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
  );

  rr_arbiter_16 #(.MAX_HOLD(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // The winner is the nearest requester after the last grant, going round the ring.
  function automatic int nearest_after(input logic [15:0] v, input int last);
    for (int k = 1; k <= 16; k++)
      if (v[(last + k) % 16]) return (last + k) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_idx[d]  = 0;
      m_last[d] = 15;   // search after reset starts at index 0
      m_hold[d] = 0;
    end
  endtask

  task automatic model_grant(input int d, input int w);
    m_vld[d]  = 1'b1;
    m_idx[d]  = w;
    m_last[d] = w;
    m_hold[d] = 1;
  endtask

  task automatic model_step(input logic [15:0] r, input logic lk);
    for (int d = 0; d < 2; d++) begin
      logic [15:0] rest;
      if (m_vld[d] && r[m_idx[d]]) begin
        rest = r;
        rest[m_idx[d]] = 1'b0;
        if (!lk && mh[d] != 0 && m_hold[d] >= mh[d] && rest != 16'h0)
          model_grant(d, nearest_after(rest, m_last[d]));
        else if (m_hold[d] < 255)
          m_hold[d]++;
      end else if (r != 16'h0) begin
        model_grant(d, nearest_after(r, m_last[d]));
      end else begin
        m_vld[d] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] exp_a, exp_b;
    exp_a = m_vld[0] ? (16'h0001 << m_idx[0]) : 16'h0000;
    exp_b = m_vld[1] ? (16'h0001 << m_idx[1]) : 16'h0000;
    check({tag, ".vld_a"}, 32'(vld_a), 32'(m_vld[0]));
    check({tag, ".gnt_a"}, 32'(gnt_a), 32'(exp_a));
    if (m_vld[0]) check({tag, ".idx_a"}, 32'(idx_a), m_idx[0]);
    check({tag, ".vld_b"}, 32'(vld_b), 32'(m_vld[1]));
    check({tag, ".gnt_b"}, 32'(gnt_b), 32'(exp_b));
    if (m_vld[1]) check({tag, ".idx_b"}, 32'(idx_b), m_idx[1]);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step(req, lock);
    #1;
    compare_all(tag);
  endtask

  // Asserts reset between clock edges, checks the immediate clear, and
  // releases reset on the falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.gnt_a", 32'(gnt_a), 32'h0);
    check("rst.vld_a", 32'(vld_a), 32'h0);
    check("rst.idx_a", 32'(idx_a), 32'h0);
    check("rst.gnt_b", 32'(gnt_b), 32'h0);
    check("rst.vld_b", 32'(vld_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int prev;
    int run;
    rst_n = 1'b1;
    req   = 16'h0;
    lock  = 1'b0;
    #1;
    do_reset();

    // Single request: one-cycle latency, then clear on release
    req = 16'h0010;
    step("single");
    check("single.gnt", 32'(gnt_a), 32'h0010);
    check("single.idx", 32'(idx_a), 32'd4);
    req = 16'h0000;
    step("single_drop");
    check("single_drop.vld", 32'(vld_a), 32'h0);

    // Full contention with MAX_HOLD=8: rotate 0..15,0 with 8-cycle tenures
    do_reset();
    req  = 16'hFFFF;
    prev = -1;
    run  = 0;
    for (int i = 0; i < 17 * 8 + 1; i++) begin
      step("rot");
      check("rot.ones", 32'($countones(gnt_a)), 32'd1);
      if (int'(idx_a) != prev) begin
        if (prev >= 0) begin
          check("rot.len", run, 8);
          check("rot.next", 32'(idx_a), (prev + 1) % 16);
        end
        prev = int'(idx_a);
        run  = 1;
      end else begin
        run++;
      end
    end

    // Two requesters, unlimited hold: hand off on release with no idle cycle
    do_reset();
    req = 16'h8008;
    step("pair");
    check("pair.idx_b", 32'(idx_b), 32'd3);
    req = 16'h8000;
    step("pair_hand");
    check("pair_hand.idx_b", 32'(idx_b), 32'd15);
    check("pair_hand.vld_b", 32'(vld_b), 32'd1);
    req = 16'h0008;
    step("pair_back");
    check("pair_back.idx_b", 32'(idx_b), 32'd3);

    // Lone requester holds for a long time; the saturated counter still
    // allows preemption once contention appears
    do_reset();
    req = 16'h0020;
    for (int i = 0; i < 300; i++) begin
      step("lone");
      check("lone.idx_a", 32'(idx_a), 32'd5);
    end
    req = 16'h0021;
    step("lone_contend");
    check("lone_contend.idx_a", 32'(idx_a), 32'd0);
    check("lone_contend.idx_b", 32'(idx_b), 32'd5);

    // Mid-cycle reset during a grant, then restart from index 0
    do_reset();
    req = 16'h0200;
    step("pre_rst");
    check("pre_rst.idx_a", 32'(idx_a), 32'd9);
    step("pre_rst2");
    do_reset();
    req = 16'hFFFF;
    step("post_rst");
    check("post_rst.idx_a", 32'(idx_a), 32'd0);
    check("post_rst.idx_b", 32'(idx_b), 32'd0);

`ifdef RR_ARB_LOCK_EN
    // Lock suppresses preemption; dropping it preempts at the next edge
    do_reset();
    req  = 16'h0003;
    lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("lock");
      check("lock.idx_a", 32'(idx_a), 32'd0);
    end
    lock = 1'b0;
    step("unlock");
    check("unlock.idx_a", 32'(idx_a), 32'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0: req = 16'($urandom);
        1: req = 16'h0001 << $urandom_range(0, 15);
        2: req = req ^ (16'h0001 << $urandom_range(0, 15));
        3: req = 16'($urandom) & 16'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 49) == 0) req = 16'h0;
`ifdef RR_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      step("rand");
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
